mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Sole owner of the cache's memory bus. Arbitrates three line-sized requesters: dirty-line writeback, D-side fill, I-side fill.
//  Runs one bus transaction at a time: request/ack, then 8 data beats out (write) or 8 beats in (read).
//  Hands filled 512-bit lines back to the cache.
// PARAMETERS
//  BUS_DATA_WIDTH  64  width of bus_req/bus_resp and of one beat
//  BUS_TAG_WIDTH   13  width of bus_reqtag/bus_resptag
//  BEATS           8   beats per cache line (64 B line / 8 B beat)
//  ISTARVE         4   consecutive lost arbitrations after which I-fill beats D-fill
// PORTS
//  clk             in   1     clock
//  reset           in   1     synchronous, active-low reset
//  wb_valid        in   1     writeback pending; held until wb_grant
//  wb_addr         in   64    writeback line address
//  wb_line         in   512   dirty line data; beat k = bits [64k+63:64k]
//  wb_grant        out  1     1-cycle pulse: wb_addr/wb_line captured
//  wb_done         out  1     1-cycle pulse: memory completed the write
//  d_valid/i_valid in   1     fill request pending; held until own grant
//  d_addr/i_addr   in   64    fill address (any byte in the line)
//  d_grant/i_grant out  1     1-cycle pulse: request accepted
//  fill_valid      out  1     1-cycle pulse: fill_line is valid
//  fill_id         out  1     0 = I-side, 1 = D-side; valid with fill_valid
//  fill_line       out  512   assembled line; beat k = bits [64k+63:64k]
//  busy            out  1     1 whenever state != IDLE
//  proto_err       out  1     sticky; cleared only by reset
//  bus_reqcyc      out  1     bus request cycle
//  bus_req         out  64    address, then write data beats
//  bus_reqtag      out  13    MEM_READ or MEM_WRITE
//  bus_reqack      in   1     bus accepted the request
//  bus_respcyc     in   1     response beat present
//  bus_resp        in   64    response beat data
//  bus_resptag     in   13    response tag
//  bus_respack     out  1     response beat acknowledged
// BEHAVIOUR
//  Reset (reset==0 at posedge): state=IDLE; every output 0; beat counter 0; starve counter 0; partial line discarded, no fill_valid/wb_done.
//  Arbitration (IDLE only, 1 decision/cycle): wb > d > i.
//   Exception: if starve counter == ISTARVE, i beats d, but never wb. Starve counter +1 when i_valid loses; 0 on i_grant.
//  Grant cycle: the winner's grant pulses; its address is latched as addr & ~64'h3F; the line is latched (wb only); go to REQ.
//  REQ: bus_reqcyc=1, bus_req=latched address, bus_reqtag=MEM_WRITE/MEM_READ. Holds until bus_reqack==1.
//   On ack: a write goes to WDATA with beat=0; a read goes to RDATA with beat=0, reqcyc=0, req=0, tag=0.
//  WDATA: bus_reqcyc stays 1; beat k drives bus_req in the k-th cycle after ack. After beat 7: reqcyc/req/tag=0, go to WACK.
//  WACK: first bus_respcyc with resptag==MEM_WRITE: bus_respack=1 next cycle; wb_done pulses; go to IDLE.
//  RDATA: each cycle bus_respcyc==1 with resptag==MEM_READ: beat[cnt]<=bus_resp; cnt+1; bus_respack=1 next cycle (registered).
//   Gaps (respcyc==0) allowed; no ack for a gap.
//   When cnt wraps 7->0: fill_line/fill_id/fill_valid driven next cycle; go to IDLE.
//  Any respcyc with unexpected tag (RDATA, WACK): ack it; set proto_err; do not advance.
//  Earliest re-arbitration: the cycle after wb_done/fill_valid. No overlap or pipelining of transactions.
//  A requester dropping valid before its grant is legal; it is simply not served.
//  Read latency: ack + 8 beats + 1 cycle.
// STRUCTURE
//  Package cache_bus_pkg:
//   MEM_READ/MEM_WRITE tag constants, BEATS, LINE_MASK
//   arb_state_e {IDLE,REQ,WDATA,WACK,RDATA}, req_id_e {REQ_I,REQ_D,REQ_WB}, line_t = logic [511:0]
//  Sub-module bus_beat_buffer: 8x64 register, 3-bit beat counter; parallel load + serialize out, or serial capture + parallel out; last-beat flag.
//  The top level holds the FSM, arbiter, starve counter and bus output registers.
// TESTING
//  Lone D-fill at 0x1234: reqack on cycle 2, beats 0..7 -> bus_req=0x1200 tag MEM_READ; one fill_valid, fill_id=1, beat k at fill_line[64k+:64]; 8 respacks.
//  wb(0x4000), d and i valid in the same cycle -> grants in order wb, d, i; 8 write beats equal wb_line; wb_done before d_grant.
//  d_valid held continuously, i_valid held -> i loses 4 times, i_grant on the 5th arbitration, then starve counter returns to 0.
//  Read beats with 3 idle gaps -> still exactly 8 beats captured, fill_valid once, respack never on a gap cycle.
//  reset low during RDATA beat 5 -> next cycle all outputs 0, no fill_valid; a new d request is served cleanly.
//  MEM_WRITE-tagged beat during RDATA -> proto_err=1, beat acked, beat counter unchanged.

Source files
------------

// File: rtl/cache_bus_pkg.sv
// ============================================================================
//  Module      : cache_bus_pkg
//  Description : Shared constants and types for the cache memory-bus slice:
//                bus transaction tags, line geometry, arbiter FSM states and
//                requester identifiers.
//  Contents    : MEM_READ / MEM_WRITE  bus tag values
//                BEATS / LINE_MASK     line geometry
//                arb_state_e           arbiter FSM state encoding
//                req_id_e              requester identifier
//                line_t                one 512-bit cache line
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_bus_pkg;

    localparam int          BEATS     = 8;
    localparam logic [12:0] MEM_READ  = 13'h0011;
    localparam logic [12:0] MEM_WRITE = 13'h0012;

    // Clears the byte-in-line offset of a 64 B line.
    localparam logic [63:0] LINE_MASK = ~64'h3F;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WDATA = 3'd2,
        WACK  = 3'd3,
        RDATA = 3'd4
    } arb_state_e;

    typedef enum logic [1:0] {
        REQ_I  = 2'd0,
        REQ_D  = 2'd1,
        REQ_WB = 2'd2
    } req_id_e;

    typedef logic [511:0] line_t;

    function automatic logic [63:0] line_base(input logic [63:0] addr);
        return addr & LINE_MASK;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bus_beat_buffer.sv
// ============================================================================
//  Module      : bus_beat_buffer
//  Description : BEATS x DATA_W line buffer with a beat counter. Either
//                parallel-loads a line and serializes it out one beat per
//                shift, or captures beats serially and presents the whole
//                line in parallel.
//  Ports       : clk, reset (sync, active-low)
//                i_load/i_line   parallel load, counter to 0
//                i_clear         counter to 0, data kept
//                i_capture/i_beat store beat at counter, advance
//                i_shift         advance counter (serialize out)
//                o_beat          beat selected by counter
//                o_line          all beats, beat k at [k*DATA_W +: DATA_W]
//                o_cnt / o_last  counter and "counter at final beat"
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_beat_buffer
    import cache_bus_pkg::*;
#(
    parameter  int DATA_W = 64,
    parameter  int NBEATS = BEATS,
    localparam int CNT_W  = $clog2(NBEATS)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_load,
    input  logic [NBEATS*DATA_W-1:0]   i_line,
    input  logic                       i_clear,
    input  logic                       i_capture,
    input  logic [DATA_W-1:0]          i_beat,
    input  logic                       i_shift,
    output logic [DATA_W-1:0]          o_beat,
    output logic [NBEATS*DATA_W-1:0]   o_line,
    output logic [CNT_W-1:0]           o_cnt,
    output logic                       o_last
);

    logic [DATA_W-1:0] r_beats [NBEATS];
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;

    assign o_last     = (r_cnt == CNT_W'(NBEATS - 1));
    assign w_cnt_next = o_last ? '0 : r_cnt + 1'b1;
    assign o_beat     = r_beats[r_cnt];
    assign o_cnt      = r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt <= '0;
            for (int k = 0; k < NBEATS; k++) begin
                r_beats[k] <= '0;
            end
        end else if (i_load) begin
            r_cnt <= '0;
            for (int k = 0; k < NBEATS; k++) begin
                r_beats[k] <= i_line[k*DATA_W +: DATA_W];
            end
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_capture) begin
            r_beats[r_cnt] <= i_beat;
            r_cnt          <= w_cnt_next;
        end else if (i_shift) begin
            r_cnt <= w_cnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NBEATS; gi++) begin : g_pack
            assign o_line[gi*DATA_W +: DATA_W] = r_beats[gi];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
//  Module      : mem_bus_arbiter
//  Description : Sole owner of the cache memory bus. Arbitrates writeback,
//                D-fill and I-fill line requests (wb > d > i, with an I-side
//                anti-starvation override), then runs one bus transaction at
//                a time: request/ack followed by BEATS write beats out or
//                BEATS read beats in. Completed read lines are returned on
//                fill_line with a one-cycle fill_valid.
//  Ports       : clk, reset (sync, active-low)
//                wb_*   writeback request / grant / done
//                d_*    D-side fill request / grant
//                i_*    I-side fill request / grant
//                fill_* returned line, id (0=I, 1=D), valid pulse
//                busy, proto_err (sticky)
//                bus_*  memory bus request and response channels
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
    import cache_bus_pkg::*;
#(
    parameter  int BUS_DATA_WIDTH = 64,
    parameter  int BUS_TAG_WIDTH  = 13,
    parameter  int BEATS          = 8,
    parameter  int ISTARVE        = 4,
    localparam int LINE_W         = BUS_DATA_WIDTH * BEATS
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      wb_valid,
    input  logic [63:0]               wb_addr,
    input  logic [LINE_W-1:0]         wb_line,
    output logic                      wb_grant,
    output logic                      wb_done,

    input  logic                      d_valid,
    input  logic [63:0]               d_addr,
    output logic                      d_grant,
    input  logic                      i_valid,
    input  logic [63:0]               i_addr,
    output logic                      i_grant,

    output logic                      fill_valid,
    output logic                      fill_id,
    output logic [LINE_W-1:0]         fill_line,
    output logic                      busy,
    output logic                      proto_err,

    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    output logic                      bus_respack
);

    localparam int                     CNT_W     = $clog2(BEATS);
    localparam int                     STARVE_W  = $clog2(ISTARVE + 1);
    localparam logic [BUS_TAG_WIDTH-1:0] c_TAG_RD = BUS_TAG_WIDTH'(MEM_READ);
    localparam logic [BUS_TAG_WIDTH-1:0] c_TAG_WR = BUS_TAG_WIDTH'(MEM_WRITE);

    arb_state_e                r_state;
    req_id_e                   r_id;
    logic                      r_is_write;
    logic [STARVE_W-1:0]       r_starve;

    logic                      r_wb_grant, r_d_grant, r_i_grant;
    logic                      r_wb_done, r_fill_valid, r_fill_id;
    logic                      r_proto_err;
    logic                      r_reqcyc, r_respack;
    logic [BUS_DATA_WIDTH-1:0] r_bus_req;
    logic [BUS_TAG_WIDTH-1:0]  r_reqtag;

    logic                      w_any_valid;
    logic                      w_i_starved;
    logic                      w_pick_i, w_pick_d;
    logic [63:0]               w_sel_addr;
    logic                      w_rd_beat, w_wr_ack;

    logic                      w_buf_load, w_buf_clear, w_buf_capture, w_buf_shift;
    logic [BUS_DATA_WIDTH-1:0] w_buf_beat;
    logic [LINE_W-1:0]         w_buf_line;
    logic [CNT_W-1:0]          w_buf_cnt;
    logic                      w_buf_last;

    // ------------------------------------------------------------------
    // Arbitration: writeback always wins; a starved I-fill overrides D-fill.
    // ------------------------------------------------------------------
    assign w_any_valid = wb_valid | d_valid | i_valid;
    assign w_i_starved = (r_starve == STARVE_W'(ISTARVE));
    assign w_pick_i    = !wb_valid && i_valid && (w_i_starved || !d_valid);
    assign w_pick_d    = !wb_valid && d_valid && !w_pick_i;

    always_comb begin
        w_sel_addr = i_addr;
        if (wb_valid) begin
            w_sel_addr = wb_addr;
        end else if (w_pick_d) begin
            w_sel_addr = d_addr;
        end
    end

    assign w_rd_beat = bus_respcyc && (bus_resptag == c_TAG_RD);
    assign w_wr_ack  = bus_respcyc && (bus_resptag == c_TAG_WR);

    // ------------------------------------------------------------------
    // Beat buffer control. A write transaction shifts once on the request
    // ack (beat 0 goes out) and then once per WDATA cycle; the counter
    // wrapping back to 0 inside WDATA marks that beat BEATS-1 has been sent.
    // ------------------------------------------------------------------
    always_comb begin
        w_buf_load    = 1'b0;
        w_buf_clear   = 1'b0;
        w_buf_capture = 1'b0;
        w_buf_shift   = 1'b0;
        case (r_state)
            IDLE:  w_buf_load    = wb_valid;
            REQ: begin
                if (bus_reqack) begin
                    w_buf_shift = r_is_write;
                    w_buf_clear = !r_is_write;
                end
            end
            WDATA: w_buf_shift   = (w_buf_cnt != '0);
            RDATA: w_buf_capture = w_rd_beat;
            default: ;
        endcase
    end

    bus_beat_buffer #(
        .DATA_W (BUS_DATA_WIDTH),
        .NBEATS (BEATS)
    ) u_beat_buffer (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_buf_load),
        .i_line    (wb_line),
        .i_clear   (w_buf_clear),
        .i_capture (w_buf_capture),
        .i_beat    (bus_resp),
        .i_shift   (w_buf_shift),
        .o_beat    (w_buf_beat),
        .o_line    (w_buf_line),
        .o_cnt     (w_buf_cnt),
        .o_last    (w_buf_last)
    );

    // ------------------------------------------------------------------
    // Transaction FSM and registered bus outputs.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_id         <= REQ_I;
            r_is_write   <= 1'b0;
            r_starve     <= '0;
            r_wb_grant   <= 1'b0;
            r_d_grant    <= 1'b0;
            r_i_grant    <= 1'b0;
            r_wb_done    <= 1'b0;
            r_fill_valid <= 1'b0;
            r_fill_id    <= 1'b0;
            r_proto_err  <= 1'b0;
            r_reqcyc     <= 1'b0;
            r_respack    <= 1'b0;
            r_bus_req    <= '0;
            r_reqtag     <= '0;
        end else begin
            r_wb_grant   <= 1'b0;
            r_d_grant    <= 1'b0;
            r_i_grant    <= 1'b0;
            r_wb_done    <= 1'b0;
            r_fill_valid <= 1'b0;
            r_respack    <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_any_valid) begin
                        r_wb_grant <= wb_valid;
                        r_d_grant  <= w_pick_d;
                        r_i_grant  <= w_pick_i;
                        r_is_write <= wb_valid;
                        r_id       <= wb_valid ? REQ_WB : (w_pick_d ? REQ_D : REQ_I);
                        r_reqcyc   <= 1'b1;
                        r_bus_req  <= BUS_DATA_WIDTH'(line_base(w_sel_addr));
                        r_reqtag   <= wb_valid ? c_TAG_WR : c_TAG_RD;
                        r_state    <= REQ;
                        // Saturating so a writeback winning against a starved
                        // I-fill keeps the override armed.
                        if (w_pick_i) begin
                            r_starve <= '0;
                        end else if (i_valid && !w_i_starved) begin
                            r_starve <= r_starve + 1'b1;
                        end
                    end
                end

                REQ: begin
                    if (bus_reqack) begin
                        if (r_is_write) begin
                            r_bus_req <= w_buf_beat;
                            r_state   <= WDATA;
                        end else begin
                            r_reqcyc  <= 1'b0;
                            r_bus_req <= '0;
                            r_reqtag  <= '0;
                            r_state   <= RDATA;
                        end
                    end
                end

                WDATA: begin
                    if (w_buf_cnt == '0) begin
                        r_reqcyc  <= 1'b0;
                        r_bus_req <= '0;
                        r_reqtag  <= '0;
                        r_state   <= WACK;
                    end else begin
                        r_bus_req <= w_buf_beat;
                    end
                end

                WACK: begin
                    if (bus_respcyc) begin
                        r_respack <= 1'b1;
                        if (w_wr_ack) begin
                            r_wb_done <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_proto_err <= 1'b1;
                        end
                    end
                end

                RDATA: begin
                    if (bus_respcyc) begin
                        r_respack <= 1'b1;
                        if (w_rd_beat) begin
                            if (w_buf_last) begin
                                r_fill_valid <= 1'b1;
                                r_fill_id    <= (r_id == REQ_D);
                                r_state      <= IDLE;
                            end
                        end else begin
                            r_proto_err <= 1'b1;
                        end
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign wb_grant    = r_wb_grant;
    assign d_grant     = r_d_grant;
    assign i_grant     = r_i_grant;
    assign wb_done     = r_wb_done;
    assign fill_valid  = r_fill_valid;
    assign fill_id     = r_fill_id;
    assign fill_line   = w_buf_line;
    assign busy        = (r_state != IDLE);
    assign proto_err   = r_proto_err;
    assign bus_reqcyc  = r_reqcyc;
    assign bus_req     = r_bus_req;
    assign bus_reqtag  = r_reqtag;
    assign bus_respack = r_respack;

endmodule

`default_nettype wire
